mult_div_unit: RTL

- Multi-cycle multiply/divide responder that owns the architectural HI/LO registers.
- The execute stage issues MUL/MULU/DIV/DIVU requests to it instead of computing {hi,lo} combinationally.
- The stage reads hi/lo back for MFHI/MFLO, and holds the pipeline while busy is high.
- Algorithm: iterative radix-2 shift-add multiply and restoring divide, one iteration per cycle.

---
 rtl/mult_div_unit_pkg.sv | 29 ++
 rtl/mult_div_unit_if.sv | 34 +++
 rtl/mult_div_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit_pkg
// Description : Shared widths, ALU op codes and FSM state encoding for the
//               multi-cycle multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_div_unit_pkg;

    localparam int c_data_bus     = 32;
    localparam int c_alu_op_width = 5;

    // ALU op codes shared with the execute stage; only the four mul/div codes
    // are acted on by the unit.
    localparam logic [c_alu_op_width-1:0] c_alu_op_add  = 5'd1;
    localparam logic [c_alu_op_width-1:0] c_alu_op_mul  = 5'd10;
    localparam logic [c_alu_op_width-1:0] c_alu_op_mulu = 5'd11;
    localparam logic [c_alu_op_width-1:0] c_alu_op_div  = 5'd12;
    localparam logic [c_alu_op_width-1:0] c_alu_op_divu = 5'd13;

    // Unit state encoding (2-bit).
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CALC   = 2'b01,
        ST_FINISH = 2'b10
    } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit_if
// Description : Request/response bundle between the execute stage (master)
//               and the multiply/divide unit (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_div_unit_if
    import mult_div_unit_pkg::*;
#(
    parameter int DATA_WIDTH   = c_data_bus,
    parameter int ALU_OP_WIDTH = c_alu_op_width
);
    logic                    stall;
    logic                    start;
    logic [ALU_OP_WIDTH-1:0] op;
    logic [DATA_WIDTH-1:0]   rs;
    logic [DATA_WIDTH-1:0]   rt;
    logic                    busy;
    logic                    done;
    logic [DATA_WIDTH-1:0]   hi;
    logic [DATA_WIDTH-1:0]   lo;

    modport master (
        output stall, start, op, rs, rt,
        input  busy, done, hi, lo
    );

    modport slave (
        input  stall, start, op, rs, rt,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative radix-2 shift-add multiplier and restoring divider
//               owning the HI/LO registers. One iteration per unstalled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int DATA_WIDTH   = c_data_bus,
    parameter int ALU_OP_WIDTH = c_alu_op_width
) (
    input  logic           clk,
    input  logic           rst,
    mult_div_unit_if.slave bus
);

    localparam int                 c_cnt_w     = $clog2(DATA_WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(DATA_WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    // Two's-complement negate when en is set; used for magnitudes and fixups.
    function automatic logic [DATA_WIDTH-1:0] f_cond_neg(
        input logic [DATA_WIDTH-1:0] x,
        input logic                  en
    );
        return en ? -x : x;
    endfunction

    mdu_state_e                  r_state;
    mdu_state_e                  w_next;
    logic                        w_write;
    logic [c_cnt_w-1:0]          r_cnt;
    logic [2*DATA_WIDTH-1:0]     r_acc;      // mul: {partial, multiplier}; div: low half = quotient
    logic [DATA_WIDTH-1:0]       r_rem;
    logic [DATA_WIDTH-1:0]       r_mag;      // mul: |multiplicand|; div: |divisor|
    logic                        r_is_div;
    logic                        r_neg_res;
    logic                        r_neg_rem;
    logic                        r_div_zero;
    logic                        r_done;
    logic [DATA_WIDTH-1:0]       r_hi;
    logic [DATA_WIDTH-1:0]       r_lo;

    // Request decode
    logic w_is_mul, w_is_mulu, w_is_div, w_is_divu, w_md_op, w_signed_op, w_div_op;
    logic w_rs_neg, w_rt_neg, w_accept;
    logic [DATA_WIDTH-1:0] w_abs_rs, w_abs_rt;

    assign w_is_mul    = (bus.op == c_alu_op_mul);
    assign w_is_mulu   = (bus.op == c_alu_op_mulu);
    assign w_is_div    = (bus.op == c_alu_op_div);
    assign w_is_divu   = (bus.op == c_alu_op_divu);
    assign w_md_op     = w_is_mul | w_is_mulu | w_is_div | w_is_divu;
    assign w_signed_op = w_is_mul | w_is_div;
    assign w_div_op    = w_is_div | w_is_divu;
    assign w_rs_neg    = w_signed_op & bus.rs[DATA_WIDTH-1];
    assign w_rt_neg    = w_signed_op & bus.rt[DATA_WIDTH-1];
    assign w_abs_rs    = f_cond_neg(bus.rs, w_rs_neg);
    assign w_abs_rt    = f_cond_neg(bus.rt, w_rt_neg);
    // The done cycle still blocks acceptance: a start coinciding with the
    // pulse belongs to the operation just finishing and is not taken.
    assign w_accept    = (r_state == ST_IDLE) & bus.start & ~bus.stall & ~r_done & w_md_op;

    // One multiply step: conditionally add the multiplicand into the upper
    // half, then shift the whole accumulator right by one.
    logic [DATA_WIDTH:0]     w_mul_sum;
    logic [2*DATA_WIDTH-1:0] w_mul_next;
    assign w_mul_sum  = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                      + (r_acc[0] ? {1'b0, r_mag} : {(DATA_WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[DATA_WIDTH-1:1]};

    // One restoring-divide step on a DATA_WIDTH+1 bit partial remainder.
    logic [DATA_WIDTH:0]   w_div_shift;
    logic                  w_div_ge;
    logic [DATA_WIDTH-1:0] w_div_sub, w_div_rem_next, w_div_q_next;
    assign w_div_shift    = {r_rem, r_acc[DATA_WIDTH-1]};
    assign w_div_ge       = (w_div_shift >= {1'b0, r_mag});
    assign w_div_sub      = w_div_shift[DATA_WIDTH-1:0] - r_mag;
    assign w_div_rem_next = w_div_ge ? w_div_sub : w_div_shift[DATA_WIDTH-1:0];
    assign w_div_q_next   = {r_acc[DATA_WIDTH-2:0], w_div_ge};

    // Sign fixup of the magnitude results.
    logic [2*DATA_WIDTH-1:0] w_prod_fix;
    logic [DATA_WIDTH-1:0]   w_quot_fix, w_rem_fix;
    assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
    assign w_quot_fix = r_div_zero ? {DATA_WIDTH{1'b1}}
                                   : f_cond_neg(r_acc[DATA_WIDTH-1:0], r_neg_res);
    // With a zero divisor every step subtracts nothing, so the remainder
    // is |rs| and the fixup restores rs itself.
    assign w_rem_fix  = f_cond_neg(r_rem, r_neg_rem);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; stall freezes every transition
    always_comb begin
        w_next  = r_state;
        w_write = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = ST_CALC;
            ST_CALC:   if (!bus.stall && r_cnt == c_last_iter) w_next = ST_FINISH;
            ST_FINISH: if (!bus.stall) begin
                w_write = 1'b1;
                w_next  = ST_IDLE;
            end
            default:   w_next = ST_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and HI/LO write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
            r_mag      <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_done     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else if (!bus.stall) begin
            r_done <= w_write;
            if (w_accept) begin
                r_cnt      <= '0;
                r_rem      <= '0;
                r_is_div   <= w_div_op;
                r_neg_res  <= w_rs_neg ^ w_rt_neg;
                r_neg_rem  <= w_rs_neg;
                r_div_zero <= (bus.rt == '0);
                r_mag      <= w_div_op ? w_abs_rt : w_abs_rs;
                r_acc      <= {{DATA_WIDTH{1'b0}}, (w_div_op ? w_abs_rs : w_abs_rt)};
            end else if (r_state == ST_CALC) begin
                r_cnt <= r_cnt + c_cnt_one;
                if (r_is_div) begin
                    r_rem                  <= w_div_rem_next;
                    r_acc[DATA_WIDTH-1:0] <= w_div_q_next;
                end else begin
                    r_acc <= w_mul_next;
                end
            end
            if (w_write) begin
                if (r_is_div) begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quot_fix;
                end else begin
                    {r_hi, r_lo} <= w_prod_fix;
                end
            end
        end
    end

    assign bus.busy = (r_state != ST_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
`default_nettype wire
